// File: rtl/riscv_writeback.sv
// Writeback stage: merges ALU results and load results into one register-file
// write port. ALU results always win. Loads that cannot be written right away
// wait in a small in-order FIFO, and the FIFO drains whenever the ALU leaves
// a cycle free.
module riscv_writeback #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [ADDR_LENGTH-1:0]        alu_rd,
  input  logic [WORD_LENGTH-1:0]        alu_result,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_LENGTH-1:0]        mem_rd,
  input  logic [WORD_LENGTH-1:0]        mem_data,
  input  logic [2:0]                    mem_funct3,
  input  logic [1:0]                    mem_offset,
  output logic                          write_en,
  output logic [ADDR_LENGTH-1:0]        write_addr,
  output logic [WORD_LENGTH-1:0]        data,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][ADDR_LENGTH-1:0] fifo_rd;
  logic [FIFO_DEPTH-1:0][WORD_LENGTH-1:0] fifo_dat;
  logic [PW-1:0]          rd_ptr, wr_ptr;

  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [WORD_LENGTH-1:0] ld_val;
  logic                   accept, alu_sel, pop, byp_sel, push;

  // Ready comes only from the registered count, so a pop in the same cycle
  // never opens room early. This keeps mem_ready free of paths from the
  // selection logic.
  assign mem_ready = !reset && (pending < DEPTH_C);
  assign accept    = mem_valid && mem_ready;

  // Extract the addressed byte or halfword, then sign- or zero-extend it
  // according to the load type.
  always_comb begin
    ld_byte = mem_data[{mem_offset, 3'b000} +: 8];
    ld_half = mem_data[{mem_offset[1], 4'b0000} +: 16];
    case (mem_funct3)
      3'b000:  ld_val = {{(WORD_LENGTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{(WORD_LENGTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_val = {{(WORD_LENGTH-8){1'b0}}, ld_byte};
      3'b101:  ld_val = {{(WORD_LENGTH-16){1'b0}}, ld_half};
      default: ld_val = mem_data;
    endcase
  end

  // Priority: ALU, then the oldest buffered load, then a fresh load that
  // bypasses an empty FIFO. Results for x0 are dropped, but the load is
  // still handshaken.
  always_comb begin
    alu_sel = alu_valid && (alu_rd != '0);
    pop     = !alu_sel && (pending != '0);
    byp_sel = !alu_sel && (pending == '0) && accept && (mem_rd != '0);
    push    = accept && (mem_rd != '0) && !byp_sel;
  end

  // Registered write port; address and data hold their values on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      data       <= '0;
    end else if (alu_sel) begin
      write_en   <= 1'b1;
      write_addr <= alu_rd;
      data       <= alu_result;
    end else if (pop) begin
      write_en   <= 1'b1;
      write_addr <= fifo_rd[rd_ptr];
      data       <= fifo_dat[rd_ptr];
    end else if (byp_sel) begin
      write_en   <= 1'b1;
      write_addr <= mem_rd;
      data       <= ld_val;
    end else begin
      write_en   <= 1'b0;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the
  // depth is a power of two. Reset empties the FIFO, so stale entries are
  // never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      pending <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (push && !pop)      pending <= pending + CW'(1);
      else if (pop && !push) pending <= pending - CW'(1);
    end
  end

  // FIFO storage. It has no reset because the pointers alone decide which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]  <= mem_rd;
      fifo_dat[wr_ptr] <= ld_val;
    end
  end

endmodule

// File: tb/tb_riscv_writeback.sv
// Bench for riscv_writeback: a queue-based reference model predicts every
// output cycle. Directed scenarios pin the model with literal values, and a
// long randomized run follows.
module tb_riscv_writeback;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_offset;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] data;
  logic [1:0]  pending;

  riscv_writeback #(.WORD_LENGTH(32), .ADDR_LENGTH(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_funct3(mem_funct3), .mem_offset(mem_offset),
    .write_en(write_en), .write_addr(write_addr), .data(data), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] v; } ent_t;
  ent_t        q[$];
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load extension computed arithmetically from the shifted word.
  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
      3'd1: return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return d;
    endcase
  endfunction

  // One clock cycle. Check ready against the model, advance the model, and
  // compare every output after the edge.
  task automatic step(output bit acc);
    bit   rdy, byp;
    ent_t e;
    logic [31:0] lv;
    #1;
    rdy = !reset && (q.size() < DEPTH);
    chk("mem_ready", mem_ready, rdy);
    acc = mem_valid && rdy;
    byp = 0;
    if (reset) begin
      q.delete();
      e_we = 0; e_addr = 0; e_data = 0;
    end else begin
      lv = ext(mem_funct3, mem_offset, mem_data);
      if (alu_valid && alu_rd != 0) begin
        e_we = 1; e_addr = alu_rd; e_data = alu_result;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        e_we = 1; e_addr = e.rd; e_data = e.v;
      end else if (acc && mem_rd != 0) begin
        e_we = 1; e_addr = mem_rd; e_data = lv; byp = 1;
      end else begin
        e_we = 0;
      end
      if (acc && mem_rd != 0 && !byp) begin
        e.rd = mem_rd; e.v = lv;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    chk("write_en", write_en, e_we);
    chk("write_addr", write_addr, e_addr);
    chk("data", data, e_data);
    chk("pending", pending, q.size());
  endtask

  task automatic set_load(input bit v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] d);
    mem_valid = v; mem_rd = rd; mem_funct3 = f3; mem_offset = off; mem_data = d;
  endtask

  initial begin
    bit acc;
    int nxt;
    reset = 1; alu_valid = 0; alu_rd = 0; alu_result = 0;
    set_load(0, 0, 0, 0, 0);
    step(acc); step(acc);
    chk("rst_we", write_en, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", mem_ready, 0);

    // ALU write. This is also the first cycle out of reset: ready must be up.
    reset = 0;
    #1 chk("ready_after_rst", mem_ready, 1);
    alu_valid = 1; alu_rd = 5; alu_result = 32'h1234;
    step(acc);
    chk("alu_we", write_en, 1);
    chk("alu_addr", write_addr, 5);
    chk("alu_data", data, 32'h0000_1234);

    // LB bypass with sign extension.
    alu_valid = 0;
    set_load(1, 7, 3'b000, 2'd1, 32'h0000_8000);
    step(acc);
    chk("lb_addr", write_addr, 7);
    chk("lb_data", data, 32'hFFFF_FF80);

    // LHU from the upper half.
    set_load(1, 4, 3'b101, 2'd2, 32'hBEEF_0000);
    step(acc);
    chk("lhu_data", data, 32'h0000_BEEF);
    set_load(0, 0, 0, 0, 0);
    step(acc);
    chk("idle_hold_data", data, 32'h0000_BEEF);

    // The ALU holds the port while three loads arrive. Only two fit.
    nxt = 8;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 3; alu_result = i;
      set_load(nxt <= 10, 5'(nxt), 3'b010, 2'd0, 32'h100 + nxt);
      step(acc);
      if (acc) nxt++;
    end
    chk("fill_pending", pending, 2);
    chk("fill_ready", mem_ready, 0);
    chk("fill_waiting", nxt, 10);
    alu_valid = 0;
    for (int i = 0; i < 3; i++) begin
      set_load(nxt <= 10, 5'(nxt), 3'b010, 2'd0, 32'h100 + nxt);
      step(acc);
      if (acc) nxt++;
      chk("drain_addr", write_addr, 8 + i);
      chk("drain_data", data, 32'h108 + i);
    end

    // An ALU result for x0 yields the port to the FIFO head.
    alu_valid = 1; alu_rd = 3; alu_result = 32'h55;
    set_load(1, 12, 3'b010, 2'd0, 32'h00C0_FFEE);
    step(acc);
    chk("x0_pending", pending, 1);
    alu_rd = 0; alu_result = 32'hDEAD;
    set_load(0, 0, 0, 0, 0);
    step(acc);
    chk("x0_we", write_en, 1);
    chk("x0_addr", write_addr, 12);
    chk("x0_data", data, 32'h00C0_FFEE);

    // Reset with two loads buffered drops them.
    alu_valid = 1; alu_rd = 3;
    for (int i = 0; i < 2; i++) begin
      set_load(1, 5'(13 + i), 3'b010, 2'd0, 32'h200 + i);
      step(acc);
    end
    chk("pre_rst_pending", pending, 2);
    reset = 1; alu_valid = 0;
    set_load(0, 0, 0, 0, 0);
    step(acc);
    chk("midrst_we", write_en, 0);
    chk("midrst_pending", pending, 0);
    reset = 0;
    set_load(1, 15, 3'b010, 2'd0, 32'h0000_0F0F);
    step(acc);
    chk("post_rst_accept", acc, 1);
    chk("post_rst_addr", write_addr, 15);
    chk("post_rst_data", data, 32'h0000_0F0F);
    set_load(0, 0, 0, 0, 0);
    step(acc);
    chk("post_rst_idle", write_en, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      alu_result = $urandom;
      set_load($urandom_range(0, 1) == 1,
               ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
               3'($urandom), 2'($urandom), $urandom);
      step(acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_writeback.md
RISCV_WRITEBACK -- requirements
Module: riscv_writeback

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_LENGTH, default 5, register address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of buffered load results (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port alu_valid  input  1  ALU result present this cycle; no back-pressure.
REQ-007 SHALL have port alu_rd  input  ADDR_LENGTH  ALU destination register.
REQ-008 SHALL have port alu_result  input  WORD_LENGTH  ALU result.
REQ-009 SHALL have port mem_valid  input  1  load result offered.
REQ-010 SHALL have port mem_ready  output  1  load result accepted when mem_valid && mem_ready.
REQ-011 SHALL have port mem_rd  input  ADDR_LENGTH  load destination register.
REQ-012 SHALL have port mem_data  input  WORD_LENGTH  raw aligned memory word.
REQ-013 SHALL have port mem_funct3  input  3  load type.
REQ-014 SHALL have port mem_offset  input  2  byte offset within word.
REQ-015 SHALL have port write_en  output  1  register-file write strobe.
REQ-016 SHALL have port write_addr  output  ADDR_LENGTH  register-file write address.
REQ-017 SHALL have port data  output  WORD_LENGTH  register-file write data.
REQ-018 SHALL have port pending  output  $clog2(FIFO_DEPTH)+1  buffered load count.

Function
REQ-019 SHALL register write_en, write_addr and data; one-cycle latency from selection to output.
REQ-020 SHALL treat rd==0 results (ALU or load) as discarded: never written, never buffered; a load with rd==0 is still handshaken.
REQ-021 SHALL select per cycle: ALU (alu_valid, alu_rd!=0) first; else FIFO head (pops it); else accepted load via bypass when FIFO empty; else write_en=0 next cycle.
REQ-022 SHALL enqueue an accepted load (rd!=0) not written via bypass into the FIFO tail.
REQ-023 SHALL drive mem_ready = !reset && (pending < FIFO_DEPTH), from registered count only; a same-cycle pop SHALL NOT raise mem_ready.
REQ-024 SHALL, on simultaneous pop and push, keep pending unchanged and preserve FIFO order.
REQ-025 SHALL apply load extension before bypass or enqueue: 000 LB sign-extend byte[offset]; 001 LH sign-extend half[offset[1]]; 010 LW word; 100 LBU zero-extend byte; 101 LHU zero-extend half; other codes pass word unchanged.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-027 SHALL hold write_addr and data at last values when write_en=0.

Reset
REQ-028 SHALL, while reset is high, force write_en=0, write_addr=0, data=0, pending=0, mem_ready=0, pointers=0.
REQ-029 SHALL discard buffered loads on reset mid-operation; no write from them after reset deasserts.
REQ-030 SHALL accept a load on the first cycle after reset deasserts.

Verification
REQ-031 SHALL check: alu_valid=1, rd=5, result=0x1234 -> next cycle write_en=1, write_addr=5, data=0x00001234.
REQ-032 SHALL check: load LB rd=7, mem_data=0x0000_8000, offset=1, FIFO empty, no ALU -> next cycle write x7=0xFFFFFF80.
REQ-033 SHALL check: ALU rd=3 each of 4 cycles while loads rd=8,9,10 offered -> x8,x9 buffered, mem_ready=0 with pending=2, third waits; after ALU stops, writes x8,x9,x10 in order.
REQ-034 SHALL check: alu rd=0 with pending=1 -> FIFO head written that cycle+1, x0 never written.
REQ-035 SHALL check: pending=2, reset pulsed 1 cycle -> write_en=0, pending=0, no buffered write after release; mem_ready=1 next cycle.
REQ-036 SHALL check: LHU offset=2, mem_data=0xBEEF_0000 -> data=0x0000BEEF.
